mem_resp_arb: RTL

MEM_RESP_ARB -- requirements
Module: mem_resp_arb

---
 rtl/mem_resp_arb.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_resp_arb.sv
// Single-outstanding memory request arbiter between instruction fetch and data ports.
// The data port has fixed priority; an aborted fetch still completes on the memory side but is not reported.
module mem_resp_arb #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_abort,
    output logic                if_ready,
    output logic [31:0]         if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_src_if;
    logic                r_discard;
    logic                r_m_valid;
    logic                r_m_we;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [DATA_W-1:0]   r_m_wdata;
    logic [DATA_W/8-1:0] r_m_wstrb;
    logic                r_if_ready;
    logic [31:0]         r_if_rdata;
    logic                r_d_ready;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                w_sel_d;
    logic                w_sel_if;
    logic                w_capture;

    // An abort in the same IDLE cycle vetoes the fetch; a data request always wins.
    assign w_sel_d   = d_req;
    assign w_sel_if  = if_req & ~if_abort & ~d_req;
    assign w_capture = (r_state == S_WAIT) & m_rvalid;

    // Next-state decode of the four-phase transaction FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sel_d | w_sel_if) w_state_nxt = S_REQ;
                else                    w_state_nxt = S_IDLE;
            end
            S_REQ: begin
                if (m_ready) w_state_nxt = S_WAIT;
                else         w_state_nxt = S_REQ;
            end
            S_WAIT: begin
                if (m_rvalid) w_state_nxt = S_RESP;
                else          w_state_nxt = S_WAIT;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; m_valid is the registered image of "next state is REQ"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_m_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_m_valid <= (w_state_nxt == S_REQ);
        end
    end

    // Latch the selected request; fields stay put until the next selection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src_if  <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= {ADDR_W{1'b0}};
            r_m_wdata <= {DATA_W{1'b0}};
            r_m_wstrb <= {(DATA_W/8){1'b0}};
        end else if ((r_state == S_IDLE) && w_sel_d) begin
            r_src_if  <= 1'b0;
            r_m_we    <= d_we;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
            r_m_wstrb <= d_wstrb;
        end else if ((r_state == S_IDLE) && w_sel_if) begin
            r_src_if  <= 1'b1;
            r_m_we    <= 1'b0;
            r_m_addr  <= if_addr;
            r_m_wdata <= {DATA_W{1'b0}};
            r_m_wstrb <= {(DATA_W/8){1'b0}};
        end
    end

    // Discard flag for an aborted in-flight fetch, cleared on the way back to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_discard <= 1'b0;
        end else if ((r_state == S_IDLE) || (r_state == S_RESP)) begin
            r_discard <= 1'b0;
        end else if (if_abort && r_src_if) begin
            r_discard <= 1'b1;
        end
    end

    // Response capture: the ready strobes are high exactly in the RESP cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_ready <= 1'b0;
            r_if_rdata <= 32'd0;
            r_d_ready  <= 1'b0;
            r_d_rdata  <= {DATA_W{1'b0}};
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            if (w_capture && r_src_if) begin
                // An abort arriving together with the completion still suppresses the strobe.
                r_if_ready <= ~r_discard & ~if_abort;
                r_if_rdata <= r_m_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
            end else if (w_capture) begin
                r_d_ready  <= 1'b1;
                r_d_rdata  <= m_rdata;
            end
        end
    end

    assign if_ready = r_if_ready;
    assign if_rdata = r_if_rdata;
    assign d_ready  = r_d_ready;
    assign d_rdata  = r_d_rdata;
    assign m_valid  = r_m_valid;
    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign m_wstrb  = r_m_wstrb;

endmodule
